// File: rtl/fp_norm_pkg.sv
// Shared definitions for the post-add mantissa normalizer.
//   EXP_W / MAN_W : exponent and fraction widths of the single-precision format
//   state_t       : normalizer FSM states
//   FLG_*         : bit positions inside the {ovf, unf, zero} status vector
package fp_norm_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLG_OVF  = 2;
  localparam int FLG_UNF  = 1;
  localparam int FLG_ZERO = 0;

endpackage

// File: rtl/lzc24.sv
// Combinational leading-zero counter over 24 bits.
//   bits : input vector, bit 23 is the most significant
//   cnt  : number of zeros above the highest set bit (24 when bits==0)
module lzc24 (
  input  logic [23:0] bits,
  output logic [4:0]  cnt
);

  // Scanning upward lets the highest set bit overwrite any lower hit.
  always_comb begin
    cnt = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (bits[i]) cnt = 5'(23 - i);
    end
  end

endmodule

// File: rtl/man_normalize.sv
// Post-add normalizer: turns the raw adder sum (carry, hidden, fraction) and
// the larger operand's exponent into a normalized sign/exponent/fraction with
// {ovf, unf, zero} status.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake (ready only in IDLE)
//   in_sign/exp/man      : sum sign, biased exponent, raw 25-bit mantissa
//   out_valid/out_ready  : output handshake, result held until accepted
//   out_sign/exp/man     : normalized result, hidden bit dropped
//   out_flags            : {ovf, unf, zero}
// Build option NORM_LZC_EN: left normalization done in a single NORM cycle
// using lzc24; otherwise one bit per cycle. Results are identical.
//
// state | meaning
// IDLE  | waiting for an input word, in_ready high
// NORM  | working registers being normalized
// DONE  | result presented, waiting for out_ready
module man_normalize
  import fp_norm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W+1:0] in_man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic [2:0]       out_flags
);

  state_t           state, state_nxt;
  logic             sign_r, sign_nxt;
  logic [EXP_W-1:0] exp_r, exp_nxt;
  logic [MAN_W+1:0] man_r, man_nxt;
  logic [2:0]       flags_r, flags_nxt;
  logic [EXP_W-1:0] exp_inc;

`ifdef NORM_LZC_EN
  logic [4:0]       lzc;
  logic [EXP_W-1:0] exp_m1;

  lzc24 u_lzc24 (
    .bits (man_r[MAN_W:0]),
    .cnt  (lzc)
  );

  assign exp_m1 = exp_r - EXP_W'(1);
`endif

  assign exp_inc = exp_r + EXP_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sign_r  <= 1'b0;
      exp_r   <= '0;
      man_r   <= '0;
      flags_r <= '0;
    end else begin
      state   <= state_nxt;
      sign_r  <= sign_nxt;
      exp_r   <= exp_nxt;
      man_r   <= man_nxt;
      flags_r <= flags_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sign_nxt  = sign_r;
    exp_nxt   = exp_r;
    man_nxt   = man_r;
    flags_nxt = flags_r;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sign_nxt  = in_sign;
          exp_nxt   = in_exp;
          man_nxt   = in_man;
          flags_nxt = '0;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if (man_r == '0) begin
          exp_nxt             = '0;
          flags_nxt[FLG_ZERO] = 1'b1;
          state_nxt           = DONE;
        end else if (man_r[MAN_W+1]) begin
          // Truncating right shift; reaching all-ones exponent means infinity.
          man_nxt = man_r >> 1;
          exp_nxt = exp_inc;
          if (exp_inc == '1) begin
            man_nxt            = '0;
            flags_nxt[FLG_OVF] = 1'b1;
          end
          state_nxt = DONE;
        end else if (man_r[MAN_W]) begin
          state_nxt = DONE;
        end else if (exp_r <= EXP_W'(1)) begin
          exp_nxt            = '0;
          flags_nxt[FLG_UNF] = 1'b1;
          state_nxt          = DONE;
        end else begin
`ifdef NORM_LZC_EN
          // Shifting exactly exp-1 lands on exp=1 with the hidden bit set,
          // which is still normal; only a strictly larger lzc is subnormal.
          if (EXP_W'(lzc) > exp_m1) begin
            man_nxt            = man_r << exp_m1;
            exp_nxt            = '0;
            flags_nxt[FLG_UNF] = 1'b1;
          end else begin
            man_nxt = man_r << lzc;
            exp_nxt = exp_r - EXP_W'(lzc);
          end
          state_nxt = DONE;
`else
          man_nxt = man_r << 1;
          exp_nxt = exp_r - EXP_W'(1);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_sign  = sign_r;
  assign out_exp   = exp_r;
  assign out_man   = man_r[MAN_W-1:0];
  assign out_flags = flags_r;

endmodule

// File: tb/tb_man_normalize.sv
module tb_man_normalize;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [24:0] in_man = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_man;
  logic [2:0]  out_flags;

  int checks = 0;
  int errors = 0;

`ifdef NORM_LZC_EN
  localparam bit LZC = 1'b1;
`else
  localparam bit LZC = 1'b0;
`endif

  man_normalize dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .in_man    (in_man),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_exp   (out_exp),
    .out_man   (out_man),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  // Drives one word and counts edges from the accept edge (inclusive) until
  // out_valid is seen; lat stays at 100 if the result never arrives.
  task automatic send_word(input logic s, input logic [7:0] e, input logic [24:0] m,
                           output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_man   = m;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_word();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_word(input string name, input int lat, input int lat_exp,
                            input logic s, input logic [7:0] e, input logic [22:0] m,
                            input logic [2:0] f);
    checks++;
    if (lat !== lat_exp) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, lat, lat_exp);
    end
    checks++;
    if ({out_sign, out_exp, out_man, out_flags} !== {s, e, m, f}) begin
      errors++;
      $display("FAIL %s result got s=%b e=%0d m=%h f=%b want s=%b e=%0d m=%h f=%b",
               name, out_sign, out_exp, out_man, out_flags, s, e, m, f);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, out_sign, out_exp, out_man, out_flags} !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset got valid=%b e=%0d m=%h f=%b ready=%b want all 0 ready=1",
               out_valid, out_exp, out_man, out_flags, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal();
    int lat;
    send_word(1'b0, 8'd100, 25'h0800000, lat);
    check_word("normal", lat, 2, 1'b0, 8'd100, 23'h0, 3'b000);
    release_word();
  endtask

  task automatic test_carry();
    int lat;
    send_word(1'b1, 8'd100, 25'h1800000, lat);
    check_word("carry", lat, 2, 1'b1, 8'd101, 23'h400000, 3'b000);
    release_word();
  endtask

  task automatic test_cancel();
    int lat;
    send_word(1'b0, 8'd100, 25'h0000100, lat);
    check_word("cancel", lat, LZC ? 2 : 17, 1'b0, 8'd85, 23'h0, 3'b000);
    release_word();
  endtask

  task automatic test_zero_ovf();
    int lat;
    send_word(1'b1, 8'd50, 25'h0, lat);
    check_word("zero", lat, 2, 1'b1, 8'd0, 23'h0, 3'b001);
    release_word();
    send_word(1'b0, 8'd254, 25'h1000000, lat);
    check_word("overflow", lat, 2, 1'b0, 8'd255, 23'h0, 3'b100);
    release_word();
  endtask

  task automatic test_underflow();
    int lat;
    send_word(1'b0, 8'd3, 25'h0000010, lat);
    check_word("underflow", lat, LZC ? 2 : 4, 1'b0, 8'd0, 23'h000040, 3'b010);
    release_word();
    // Shift exactly reaches exp=1 with hidden bit set: stays normal.
    send_word(1'b0, 8'd4, 25'h0100000, lat);
    check_word("exp_edge", lat, LZC ? 2 : 5, 1'b0, 8'd1, 23'h0, 3'b000);
    release_word();
    // Already at exp=1 without hidden bit: subnormal, fraction untouched.
    send_word(1'b1, 8'd1, 25'h0400000, lat);
    check_word("exp_one", lat, 2, 1'b1, 8'd0, 23'h400000, 3'b010);
    release_word();
  endtask

  task automatic test_backpressure();
    int lat;
    send_word(1'b1, 8'd100, 25'h1800000, lat);
    check_word("bp_word", lat, 2, 1'b1, 8'd101, 23'h400000, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_sign, out_exp, out_man, out_flags} !==
          {1'b1, 1'b0, 1'b1, 8'd101, 23'h400000, 3'b000}) begin
        errors++;
        $display("FAIL backpressure cycle %0d got v=%b r=%b e=%0d m=%h want v=1 r=0 e=101 m=400000",
                 i, out_valid, in_ready, out_exp, out_man);
      end
    end
    // Hold in_valid high through the release: it must not be taken on the
    // release edge, only one edge later.
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 8'd100;
    in_man   = 25'h0800000;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bubble got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_exp !== 8'd100 || out_sign !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back got valid=%b e=%0d s=%b want valid=1 e=100 s=0",
               out_valid, out_exp, out_sign);
    end
    release_word();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_exp   = 8'd100;
    in_man   = 25'h0000100;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_output got out_valid seen=%b want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_carry();
    test_cancel();
    test_zero_ovf();
    test_underflow();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
